// File: rtl/load_writeback.sv
// Buffered load-result stage: extracts/extends the addressed lane of a dbus word at
// enqueue and holds results in a small FIFO until the register-file write port grants them.
module load_writeback #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [2:0]  in_size,
    input  logic        in_signed,
    input  logic [4:0]  in_dst,
    input  logic [31:0] in_data,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_dst,
    output logic [31:0] wb_data,
    output logic        wb_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        MSIZE_BYTE = 3'b000,
        MSIZE_HALF = 3'b001,
        MSIZE_WORD = 3'b010
    } msize_t;

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] data;
        logic        err;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        new_entry;
    entry_t        head;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [1:0]    lane;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic          enq;
    logic          store;
    logic          deq;

    // Lane extraction, extension and alignment check happen once, at enqueue.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lane      = in_addr[1:0];
        byte_v    = 8'h00;
        half_v    = lane[1] ? in_data[31:16] : in_data[15:0];
        new_entry = '{dst: in_dst, data: 32'h0, err: 1'b0};
        case (lane)
            2'd0:    byte_v = in_data[7:0];
            2'd1:    byte_v = in_data[15:8];
            2'd2:    byte_v = in_data[23:16];
            default: byte_v = in_data[31:24];
        endcase
        case (msize_t'(in_size))
            MSIZE_BYTE: new_entry.data = {{24{in_signed & byte_v[7]}}, byte_v};
            MSIZE_HALF: begin
                if (lane[0]) new_entry.err = 1'b1;
                else         new_entry.data = {{16{in_signed & half_v[15]}}, half_v};
            end
            MSIZE_WORD: begin
                if (lane != 2'd0) new_entry.err = 1'b1;
                else              new_entry.data = in_data;
            end
            default:    new_entry.err = 1'b1;
        endcase
        if (new_entry.err) new_entry.data = in_addr;
    end

    assign in_ready = (count != CW'(DEPTH));
    assign wb_valid = (count != '0);
    assign enq      = in_valid && in_ready && !flush;
    // Writes to x0 are acknowledged but never stored; faults on x0 must still be reported.
    assign store    = enq && ((in_dst != 5'd0) || new_entry.err);
    assign deq      = wb_valid && wb_ready && !flush;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (store) wr_ptr <= wr_ptr + PW'(1);
            if (deq)   rd_ptr <= rd_ptr + PW'(1);
            case ({store, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; count alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (store) mem[wr_ptr] <= new_entry;
    end

    assign head    = mem[rd_ptr];
    assign wb_dst  = wb_valid ? head.dst  : 5'd0;
    assign wb_data = wb_valid ? head.data : 32'h0;
    assign wb_err  = wb_valid ? head.err  : 1'b0;

endmodule

// File: tb/tb_load_writeback.sv
// Self-checking bench for load_writeback: directed steps from the load scenarios followed by
// random traffic, all compared every cycle against a queue-based reference model.
module tb_load_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [2:0]  in_size;
    logic        in_signed;
    logic [4:0]  in_dst;
    logic [31:0] in_data;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic        wb_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0]  dst;
        logic [31:0] data;
        logic        err;
    } ent_t;

    ent_t q[$];

    load_writeback #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_size  (in_size),
        .in_signed(in_signed),
        .in_dst   (in_dst),
        .in_data  (in_data),
        .flush    (flush),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_dst   (wb_dst),
        .wb_data  (wb_data),
        .wb_err   (wb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference load semantics computed with shifts and masks on the raw word.
    task automatic ref_load(input logic [31:0] addr, input logic [2:0] size, input logic sgn,
                            input logic [31:0] data, output logic [31:0] val, output logic err);
        int o;
        o   = int'(addr % 4);
        err = 1'b0;
        val = 32'h0;
        if (size == 3'd0) begin
            val = (data >> (8 * o)) & 32'hFF;
            if (sgn && val >= 32'h80) val = val | 32'hFFFF_FF00;
        end else if (size == 3'd1) begin
            if (o % 2 != 0) err = 1'b1;
            else begin
                val = (data >> (8 * o)) & 32'hFFFF;
                if (sgn && val >= 32'h8000) val = val | 32'hFFFF_0000;
            end
        end else if (size == 3'd2) begin
            if (o != 0) err = 1'b1;
            else        val = data;
        end else begin
            err = 1'b1;
        end
        if (err) val = addr;
    endtask

    task automatic compare_model();
        check("in_ready", {31'b0, in_ready}, {31'b0, q.size() != DEPTH});
        check("wb_valid", {31'b0, wb_valid}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            check("wb_dst",  {27'b0, wb_dst}, {27'b0, q[0].dst});
            check("wb_data", wb_data, q[0].data);
            check("wb_err",  {31'b0, wb_err}, {31'b0, q[0].err});
        end else begin
            check("idle_dst",  {27'b0, wb_dst}, 32'h0);
            check("idle_data", wb_data, 32'h0);
            check("idle_err",  {31'b0, wb_err}, 32'h0);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied, then compare.
    task automatic cycle();
        int          sz;
        logic [31:0] v;
        logic        e;
        sz = q.size();
        if (flush) begin
            q.delete();
        end else begin
            if (sz != 0 && wb_ready) void'(q.pop_front());
            if (in_valid && sz != DEPTH) begin
                ref_load(in_addr, in_size, in_signed, in_data, v, e);
                if (in_dst != 5'd0 || e) q.push_back('{dst: in_dst, data: v, err: e});
            end
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic [31:0] addr, input logic [2:0] size, input logic sgn,
                         input logic [4:0] dst, input logic [31:0] data);
        in_valid  = 1'b1;
        in_addr   = addr;
        in_size   = size;
        in_signed = sgn;
        in_dst    = dst;
        in_data   = data;
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_addr   = 32'h0;
        in_size   = 3'd0;
        in_signed = 1'b0;
        in_dst    = 5'd0;
        in_data   = 32'h0;
        flush     = 1'b0;
        wb_ready  = 1'b0;

        // Reset state.
        #12;
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
        check("rst_wb_data",  wb_data, 32'h0);
        @(negedge clk);
        resetn = 1'b1;

        // Streaming extraction cases with the write port always granted.
        wb_ready = 1'b1;
        drive(32'h1003, 3'd0, 1'b1, 5'd5, 32'h80FF_1234);
        cycle();
        check("lb_valid", {31'b0, wb_valid}, 32'h1);
        check("lb_dst",   {27'b0, wb_dst}, 32'd5);
        check("lb_data",  wb_data, 32'hFFFF_FF80);
        check("lb_err",   {31'b0, wb_err}, 32'h0);
        drive(32'h1003, 3'd0, 1'b0, 5'd5, 32'h80FF_1234);
        cycle();
        check("lbu_data", wb_data, 32'h0000_0080);
        drive(32'h2002, 3'd1, 1'b1, 5'd7, 32'h8001_7FFF);
        cycle();
        check("lh_data", wb_data, 32'hFFFF_8001);
        drive(32'h2002, 3'd1, 1'b0, 5'd7, 32'h8001_7FFF);
        cycle();
        check("lhu_data", wb_data, 32'h0000_8001);
        drive(32'h2001, 3'd1, 1'b1, 5'd7, 32'h8001_7FFF);
        cycle();
        check("lh_mis_err",  {31'b0, wb_err}, 32'h1);
        check("lh_mis_data", wb_data, 32'h0000_2001);
        in_valid = 1'b0;
        cycle();
        check("stream_empty", {31'b0, wb_valid}, 32'h0);

        // Backpressure: A and B fill the buffer, C is held off until a slot frees.
        wb_ready = 1'b0;
        drive(32'h100, 3'd2, 1'b0, 5'd1, 32'hAAAA_0001);
        cycle();
        check("bp_ready_a", {31'b0, in_ready}, 32'h1);
        drive(32'h104, 3'd2, 1'b0, 5'd2, 32'hBBBB_0002);
        cycle();
        check("bp_full", {31'b0, in_ready}, 32'h0);
        drive(32'h108, 3'd2, 1'b0, 5'd3, 32'hCCCC_0003);
        cycle();
        check("bp_hold_head", {27'b0, wb_dst}, 32'd1);
        wb_ready = 1'b1;
        cycle();
        check("bp_drain_b", {27'b0, wb_dst}, 32'd2);
        cycle();
        check("bp_drain_c", {27'b0, wb_dst}, 32'd3);

        // Full with enqueue and dequeue together: only the dequeue happens.
        wb_ready = 1'b0;
        drive(32'h10C, 3'd2, 1'b0, 5'd4, 32'hDDDD_0004);
        cycle();
        check("fd_full", {31'b0, in_ready}, 32'h0);
        drive(32'h110, 3'd2, 1'b0, 5'd6, 32'hEEEE_0006);
        wb_ready = 1'b1;
        cycle();
        check("fd_slot", {31'b0, in_ready}, 32'h1);
        check("fd_head", {27'b0, wb_dst}, 32'd4);
        wb_ready = 1'b0;
        cycle();
        check("fd_refull", {31'b0, in_ready}, 32'h0);
        in_valid = 1'b0;
        wb_ready = 1'b1;
        cycle();
        cycle();

        // x0 destinations: clean loads vanish, faulting loads are reported.
        drive(32'h3000, 3'd2, 1'b0, 5'd0, 32'h1234_5678);
        cycle();
        check("x0_drop_valid", {31'b0, wb_valid}, 32'h0);
        check("x0_drop_ready", {31'b0, in_ready}, 32'h1);
        drive(32'h3002, 3'd2, 1'b0, 5'd0, 32'h1234_5678);
        cycle();
        check("x0_err_valid", {31'b0, wb_valid}, 32'h1);
        check("x0_err_err",   {31'b0, wb_err}, 32'h1);
        check("x0_err_data",  wb_data, 32'h0000_3002);
        in_valid = 1'b0;
        cycle();

        // Flush with a simultaneous offer discards everything.
        wb_ready = 1'b0;
        drive(32'h400, 3'd2, 1'b0, 5'd10, 32'h0000_000A);
        cycle();
        drive(32'h404, 3'd2, 1'b0, 5'd11, 32'h0000_000B);
        cycle();
        drive(32'h408, 3'd2, 1'b0, 5'd12, 32'h0000_000C);
        flush = 1'b1;
        cycle();
        check("flush_valid", {31'b0, wb_valid}, 32'h0);
        check("flush_ready", {31'b0, in_ready}, 32'h1);
        flush    = 1'b0;
        in_valid = 1'b0;
        cycle();
        check("flush_no_late", {31'b0, wb_valid}, 32'h0);

        // Asynchronous reset in the middle of a drain.
        drive(32'h500, 3'd2, 1'b0, 5'd13, 32'h0000_000D);
        cycle();
        drive(32'h504, 3'd2, 1'b0, 5'd14, 32'h0000_000E);
        cycle();
        in_valid = 1'b0;
        wb_ready = 1'b1;
        cycle();
        check("drain_head", {27'b0, wb_dst}, 32'd14);
        #2;
        resetn = 1'b0;
        #1;
        q.delete();
        check("async_rst_valid", {31'b0, wb_valid}, 32'h0);
        check("async_rst_ready", {31'b0, in_ready}, 32'h1);
        check("async_rst_dst",   {27'b0, wb_dst}, 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            wb_ready  = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            in_addr   = $urandom;
            in_size   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            in_signed = 1'($urandom_range(0, 1));
            in_dst    = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            in_data   = $urandom;
            cycle();
        end
        in_valid = 1'b0;
        flush    = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_writeback.md
# load_writeback

Buffered load-result stage between the refcpu Load stage (S_LOADED) and the register-file write port. It accepts the raw 32-bit dbus word together with the load's address, size, signedness and destination register. At enqueue it extracts and sign- or zero-extends the addressed byte, halfword or word, and checks alignment. Results wait in a small FIFO until the shared register-file write port grants them, so the Load stage never stalls on write-port arbitration.

## Interface
- DEPTH, 2, number of FIFO entries; power of two, ≥2.
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  load result offered.
- in_ready  out  1  asserted when the FIFO is not full.
- in_addr  in  32  load virtual address; only bits [1:0] select lanes, full value reported on error.
- in_size  in  3  msize_t: 3'b000 byte, 3'b001 half, 3'b010 word, anything else unsupported.
- in_signed  in  1  1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU); ignored for word.
- in_dst  in  5  destination GPR index.
- in_data  in  32  raw dbus response word, lanes in address position.
- flush  in  1  synchronous flush of every buffered entry.
- wb_valid  out  1  head entry present.
- wb_ready  in  1  write port granted; head consumed when wb_valid && wb_ready.
- wb_dst  out  5  head destination.
- wb_data  out  32  extended load value, or the faulting address when wb_err=1.
- wb_err  out  1  head entry is an address/size error; the consumer must not write the GPR.

## Operation
- Accept when in_valid && in_ready && !flush.
- Lane extraction uses o = in_addr[1:0]:
  - byte: in_data[8*o +: 8]
  - half: in_data[16*o[1] +: 16]
  - word: in_data
- Extension: with in_signed=1, the upper bits take the extracted MSB; with in_signed=0 they are zero.
- Error: a half with o[0]=1, a word with o≠0, or an unsupported size sets err=1 and stores in_addr in the data field. in_dst is still stored.
- Extraction and the error check are done once, at enqueue. Each entry stores {dst, data, err}.
- Accepted entries with in_dst=0 and err=0 are dropped: they are acknowledged but not stored and produce no writeback. Entries with in_dst=0 and err=1 are stored.
- Storage is a circular buffer with rd_ptr and wr_ptr, each log2(DEPTH) bits and wrapping modulo DEPTH, plus count in 0..DEPTH.
  - in_ready = (count != DEPTH). Dequeue in the same cycle does not free a slot for that cycle's enqueue.
  - Simultaneous enqueue and dequeue with 0 < count < DEPTH: count unchanged, both pointers advance.
- wb_valid = (count != 0). When count = 0, wb_dst, wb_data and wb_err are driven 0.
- Flush has priority over enqueue and dequeue. On flush, count, rd_ptr and wr_ptr become 0 on the next edge. An in_valid offered in the same cycle is dropped, and so is a head handshake in that cycle.
- Entries leave strictly in acceptance order.

## Timing
- Reset (resetn low, async) gives count=0, pointers=0, wb_valid=0, wb_dst=0, wb_data=0, wb_err=0. in_ready reads 1 during and after reset.
- Latency: an entry accepted at edge N drives wb_valid=1 from cycle N+1. There is no same-cycle bypass.
- Throughput: one enqueue and one dequeue per cycle.
- With DEPTH=2 and wb_ready held 1, back-to-back loads stream with no in_ready bubbles.
- wb_valid and head fields stay stable until consumed or flushed.
- Reset deasserted mid-stream leaves the buffer empty. Any in_valid presented before the first edge after deassertion is not accepted.

## Test plan
- LB, addr 0x1003, data 0x80FF_1234, signed, dst 5 → one cycle later wb_valid=1, wb_dst=5, wb_data=0xFFFF_FF80, wb_err=0. Repeat as LBU → 0x0000_0080.
- LH at 0x2002 with data 0x8001_7FFF: signed gives 0xFFFF_8001, unsigned gives 0x0000_8001. LH at 0x2001 gives wb_err=1, wb_data=0x0000_2001.
- wb_ready=0 with three accepts attempted (DEPTH=2): in_ready goes 0 after the second accept and the third is held off. Raising wb_ready drains dst order A, B, then C is accepted.
- Full FIFO with in_valid=1 and wb_ready=1 in the same cycle: head dequeues, in_ready stays 0 that cycle, the new entry is accepted the next cycle, and count returns to 2.
- LW with dst=0, no error → in_ready=1, no wb_valid pulse. LW at 0x3002 with dst=0 → wb_valid=1, wb_err=1.
- Two entries buffered, then flush=1 together with in_valid=1 → next cycle wb_valid=0, count=0, and the flushed-cycle input is not delivered. Asserting resetn=0 mid-drain clears wb_valid asynchronously.
